// File: rtl/gcd_issue_ctrl.sv
// Request FIFO plus issue/wait/respond sequencer in front of a GCD core, with a watchdog.
// Optional build macro GCD_ZERO_BYPASS_EN answers pairs containing a zero operand without using the core.
module gcd_issue_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [DATA_WIDTH-1:0]         req_a_i,
    input  logic [DATA_WIDTH-1:0]         req_b_i,
    output logic [DATA_WIDTH-1:0]         gcd_a_o,
    output logic [DATA_WIDTH-1:0]         gcd_b_o,
    output logic                          gcd_enable_o,
    input  logic                          gcd_done_i,
    input  logic [DATA_WIDTH-1:0]         gcd_result_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_timeout_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_VAL   = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [2*DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [1:0]              state_reg;
    logic [15:0]             wd_reg;
    logic [15:0]             wd_next;
    logic [DATA_WIDTH-1:0]   gcd_a_reg;
    logic [DATA_WIDTH-1:0]   gcd_b_reg;
    logic [DATA_WIDTH-1:0]   rsp_data_reg;
    logic                    rsp_timeout_reg;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   head_a;
    logic [DATA_WIDTH-1:0]   head_b;

    // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
    assign req_ready_o  = (count_reg != DEPTH_VAL);
    assign fifo_empty   = (count_reg == '0);
    assign push         = req_valid_i && req_ready_o;
    assign pop          = (state_reg == ST_IDLE) && !fifo_empty;
    assign head_a       = fifo_mem[rd_ptr_reg][2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_b       = fifo_mem[rd_ptr_reg][DATA_WIDTH-1:0];
    assign wd_next      = wd_reg + 16'd1;

    assign gcd_a_o       = gcd_a_reg;
    assign gcd_b_o       = gcd_b_reg;
    assign gcd_enable_o  = (state_reg == ST_ISSUE);
    assign rsp_valid_o   = (state_reg == ST_RESP);
    assign rsp_data_o    = rsp_data_reg;
    assign rsp_timeout_o = rsp_timeout_reg;
    assign fifo_count_o  = count_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {req_a_i, req_b_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg       <= ST_IDLE;
            wd_reg          <= '0;
            gcd_a_reg       <= '0;
            gcd_b_reg       <= '0;
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
`ifdef GCD_ZERO_BYPASS_EN
                        if ((head_a == '0) || (head_b == '0)) begin
                            rsp_data_reg    <= head_a | head_b;
                            rsp_timeout_reg <= 1'b0;
                            state_reg       <= ST_RESP;
                        end else begin
                            gcd_a_reg <= head_a;
                            gcd_b_reg <= head_b;
                            state_reg <= ST_ISSUE;
                        end
`else
                        gcd_a_reg <= head_a;
                        gcd_b_reg <= head_b;
                        state_reg <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    wd_reg    <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the expiry cycle still delivers the real result.
                    if (gcd_done_i) begin
                        rsp_data_reg    <= gcd_result_i;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= ST_RESP;
                    end else if (wd_next == TIMEOUT_VAL) begin
                        rsp_data_reg    <= '0;
                        rsp_timeout_reg <= 1'b1;
                        state_reg       <= ST_RESP;
                    end else begin
                        wd_reg <= wd_next;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_issue_ctrl.sv
// Directed bench for gcd_issue_ctrl: behavioural core stub plus issue/response scoreboards.
module tb_gcd_issue_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
`ifdef GCD_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [DW-1:0] req_a_i;
    logic [DW-1:0] req_b_i;
    logic [DW-1:0] gcd_a_o;
    logic [DW-1:0] gcd_b_o;
    logic          gcd_enable_o;
    logic          gcd_done_i;
    logic [DW-1:0] gcd_result_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_timeout_o;
    logic [2:0]    fifo_count_o;

    int n_vec = 0;
    int n_err = 0;
    int core_delay = 5;
    int stall_n = 0;
    logic [DW:0]     rsp_q[$];
    logic [2*DW-1:0] iss_q[$];

    always #5 clk = ~clk;

    gcd_issue_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o), .gcd_enable_o(gcd_enable_o),
        .gcd_done_i(gcd_done_i), .gcd_result_i(gcd_result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o),
        .fifo_count_o(fifo_count_o)
    );

    function automatic logic [DW-1:0] gcd_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core stub: result appears core_delay cycles after the enable cycle; stall_n skips enables.
    initial begin
        logic [DW-1:0] ca;
        logic [DW-1:0] cb;
        gcd_done_i   = 1'b0;
        gcd_result_i = '0;
        forever begin
            @(negedge clk);
            if (gcd_enable_o) begin
                if (stall_n > 0) begin
                    stall_n--;
                end else begin
                    ca = gcd_a_o;
                    cb = gcd_b_o;
                    repeat (core_delay) @(posedge clk);
                    #1 gcd_done_i = 1'b1;
                    gcd_result_i = gcd_fn(ca, cb);
                    @(posedge clk);
                    #1 gcd_done_i = 1'b0;
                    gcd_result_i = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_i && gcd_enable_o) begin
            n_vec++;
            assert (iss_q.size() != 0) else begin
                n_err++;
                $error("FAIL issue_unexpected: observed a=%0d b=%0d expected no issue", gcd_a_o, gcd_b_o);
            end
            if (iss_q.size() != 0) check("issue_ab", {16'd0, gcd_a_o, gcd_b_o}, {16'd0, iss_q.pop_front()});
        end
        if (!reset_i && rsp_valid_o && rsp_ready_i) begin
            n_vec++;
            assert (rsp_q.size() != 0) else begin
                n_err++;
                $error("FAIL rsp_unexpected: observed data=%0d expected no response", rsp_data_o);
            end
            if (rsp_q.size() != 0) check("rsp_data_to", {23'd0, rsp_data_o, rsp_timeout_o}, {23'd0, rsp_q.pop_front()});
        end
    end

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] ed, input logic et);
        req_valid_i = 1'b1;
        req_a_i     = a;
        req_b_i     = b;
        rsp_q.push_back({ed, et});
        if (!(BYPASS && (a == 0 || b == 0))) iss_q.push_back({a, b});
        @(negedge clk);
        for (int i = 0; i < 100 && !req_ready_o; i++) @(negedge clk);
        check("push_ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (rsp_q.size() != 0 || iss_q.size() != 0); i++) @(negedge clk);
        check("drain_pending", rsp_q.size() + iss_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i     = 1'b1;
        req_valid_i = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", {29'd0, fifo_count_o}, 32'd0);
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_enable", {31'd0, gcd_enable_o}, 32'd0);
        check("rst_gcd_ab", {16'd0, gcd_a_o, gcd_b_o}, 32'd0);
        check("rst_rsp_data", {23'd0, rsp_data_o, rsp_timeout_o}, 32'd0);
        @(posedge clk);
        #1 reset_i = 1'b0;

        // Single op with exact latency: enable in N+2, done in N+7, rsp_valid in N+8.
        rsp_ready_i = 1'b1;
        core_delay  = 5;
        push(8'd12, 8'd18, 8'd6, 1'b0);
        @(negedge clk);
        check("lat_enable_n1", {31'd0, gcd_enable_o}, 32'd0);
        @(negedge clk);
        check("lat_enable_n2", {31'd0, gcd_enable_o}, 32'd1);
        check("lat_issue_ab", {16'd0, gcd_a_o, gcd_b_o}, {16'd0, 8'd12, 8'd18});
        repeat (5) @(negedge clk);
        check("lat_rsp_d", {31'd0, rsp_valid_o}, 32'd0);
        @(negedge clk);
        check("lat_rsp_d1", {31'd0, rsp_valid_o}, 32'd1);
        check("lat_rsp_data", {24'd0, rsp_data_o}, 32'd6);
        @(negedge clk);
        check("lat_rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
        drain();

        // Fill: five back-to-back pushes while the core is busy.
        core_delay = 6;
        push(8'd12, 8'd8, 8'd4, 1'b0);
        push(8'd9, 8'd27, 8'd9, 1'b0);
        push(8'd10, 8'd4, 8'd2, 1'b0);
        push(8'd7, 8'd5, 8'd1, 1'b0);
        push(8'd20, 8'd30, 8'd10, 1'b0);
        @(negedge clk);
        check("fill_count", {29'd0, fifo_count_o}, 32'd4);
        check("fill_ready", {31'd0, req_ready_o}, 32'd0);
        drain();

        // Backpressure: response held stable, no new issue until the handshake.
        rsp_ready_i = 1'b0;
        core_delay  = 2;
        push(8'd9, 8'd6, 8'd3, 1'b0);
        push(8'd8, 8'd12, 8'd4, 1'b0);
        for (int i = 0; i < 50 && !rsp_valid_o; i++) @(negedge clk);
        check("bp_valid_seen", {31'd0, rsp_valid_o}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {22'd0, rsp_valid_o, rsp_data_o, gcd_enable_o}, {22'd0, 1'b1, 8'd3, 1'b0});
        end
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        drain();

        // Timeout on a silent core, then the next entry issues normally.
        core_delay = 3;
        stall_n    = 1;
        push(8'd7, 8'd14, 8'd0, 1'b1);
        push(8'd15, 8'd10, 8'd5, 1'b0);
        drain();

        // Zero operands: bypassed when the macro is defined, otherwise issued.
        push(8'd0, 8'd9, 8'd9, 1'b0);
        push(8'd6, 8'd0, 8'd6, 1'b0);
        drain();

        // Reset while waiting with two entries queued; the stale done must be ignored.
        core_delay = 20;
        push(8'd12, 8'd8, 8'd4, 1'b0);
        push(8'd3, 8'd9, 8'd3, 1'b0);
        push(8'd6, 8'd4, 8'd2, 1'b0);
        repeat (3) @(negedge clk);
        check("rstw_count_pre", {29'd0, fifo_count_o}, 32'd2);
        @(posedge clk);
        #1 reset_i = 1'b1;
        rsp_q.delete();
        iss_q.delete();
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("rstw_count", {29'd0, fifo_count_o}, 32'd0);
        check("rstw_ready", {31'd0, req_ready_o}, 32'd1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("rstw_no_rsp", {30'd0, rsp_valid_o, gcd_enable_o}, 32'd0);
        end

        // Recovery after reset.
        core_delay = 3;
        push(8'd21, 8'd14, 8'd7, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
